// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SHIFT = 2'b10,
    OP_BKSP  = 2'b11
  } op_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational digit decoder: 4-bit code to active-low segment pattern.
// The table covers all 16 codes, so the output is always defined.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit display controller: digit registers with positional write, shift-in,
// backspace and clear, scanned onto one shared active-low 7-segment bus.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000,
  parameter bit HEX_EN      = 1'b0,
  localparam int PW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          op,
  input  logic                clr,
  input  logic [PW-1:0]       wr_pos,
  input  logic [3:0]          wr_dig,
  input  logic                wr_dp,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic                err,
  output logic [PW:0]         count
);

  localparam int PSW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [3:0]          data_q [N_DIGITS];
  logic [3:0]          data_d [N_DIGITS];
  logic [N_DIGITS-1:0] valid_q, valid_d;
  logic [N_DIGITS-1:0] dpr_q, dpr_d;
  logic                err_q, err_d;
  logic [PW:0]         count_q, count_d;
  logic [PSW-1:0]      presc_q, presc_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  op_t  op_s;
  logic dig_bad, pos_bad;

  assign op_s    = op_t'(op);
  assign dig_bad = !HEX_EN && (wr_dig > 4'd9);
  assign pos_bad = ({1'b0, wr_pos} >= (PW+1)'(N_DIGITS));

  // Command path: a rejected command only raises err, clr overrides any op.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    dpr_d   = dpr_q;
    err_d   = 1'b0;
    count_d = '0;
    if (clr) begin
      for (int i = 0; i < N_DIGITS; i++) data_d[i] = 4'd0;
      valid_d = '0;
      dpr_d   = '0;
    end else begin
      case (op_s)
        OP_WRITE: begin
          if (dig_bad || pos_bad) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (wr_pos == PW'(i)) begin
                data_d[i]  = wr_dig;
                valid_d[i] = 1'b1;
                dpr_d[i]   = wr_dp;
              end
            end
          end
        end
        OP_SHIFT: begin
          if (dig_bad) begin
            err_d = 1'b1;
          end else begin
            for (int i = N_DIGITS - 1; i > 0; i--) data_d[i] = data_q[i-1];
            data_d[0] = wr_dig;
            valid_d   = {valid_q[N_DIGITS-2:0], 1'b1};
            dpr_d     = {dpr_q[N_DIGITS-2:0], wr_dp};
          end
        end
        OP_BKSP: begin
          for (int i = 0; i < N_DIGITS - 1; i++) data_d[i] = data_q[i+1];
          data_d[N_DIGITS-1] = 4'd0;
          valid_d = {1'b0, valid_q[N_DIGITS-1:1]};
          dpr_d   = {1'b0, dpr_q[N_DIGITS-1:1]};
        end
        default: ;
      endcase
    end
    for (int i = 0; i < N_DIGITS; i++) count_d = count_d + (PW+1)'(valid_d[i]);
  end

  // Scan timing is independent of the command path.
  always_comb begin
    presc_d = presc_q + PSW'(1);
    idx_d   = idx_q;
    if (presc_q == PSW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == PW'(N_DIGITS - 1)) ? '0 : idx_q + PW'(1);
    end
  end

  logic [3:0] sel_dig;
  logic       sel_v, sel_dp;
  logic [6:0] dec_seg;

  always_comb begin
    sel_dig = 4'd0;
    sel_v   = 1'b0;
    sel_dp  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == PW'(i)) begin
        sel_dig = data_q[i];
        sel_v   = valid_q[i];
        sel_dp  = dpr_q[i];
      end
    end
  end

  seg7_dec u_dec (
    .code_i (sel_dig),
    .seg_o  (dec_seg)
  );

  assign seg_d = sel_v ? dec_seg : SEG_BLANK;
  assign dpo_d = ~(sel_dp & sel_v);
  assign an_d  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIGITS; i++) data_q[i] <= 4'd0;
      valid_q <= '0;
      dpr_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      dpo_q   <= 1'b1;
      an_q    <= '1;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      dpr_q   <= dpr_d;
      err_q   <= err_d;
      count_q <= count_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dpo_q;
  assign an    = an_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed and randomized checks of seg7_scan_ctrl against a queue-based display model.
module tb_seg7_scan_ctrl;

  localparam int N   = 8;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Main build: N=8, DIV=4, HEX_EN=0
  logic [1:0] op = 2'd0;
  logic       clr = 1'b0;
  logic [2:0] wr_pos = 3'd0;
  logic [3:0] wr_dig = 4'd0;
  logic       wr_dp = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       err;
  logic [3:0] count;

  // Hex build: N=8, DIV=4, HEX_EN=1
  logic [1:0] op_h = 2'd0;
  logic [2:0] pos_h = 3'd0;
  logic [3:0] dig_h = 4'd0;
  logic [6:0] seg_h;
  logic       dp_h;
  logic [7:0] an_h;
  logic       err_h;
  logic [3:0] count_h;

  // Wide build: N=10, DIV=4, HEX_EN=0
  logic [1:0] op_w = 2'd0;
  logic [3:0] pos_w = 4'd0;
  logic [3:0] dig_w = 4'd0;
  logic [6:0] seg_w;
  logic       dp_w;
  logic [9:0] an_w;
  logic       err_w;
  logic [4:0] count_w;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_EN(1'b0)) dut (
    .clock(clk), .reset(rst_n), .op(op), .clr(clr), .wr_pos(wr_pos),
    .wr_dig(wr_dig), .wr_dp(wr_dp), .seg(seg), .dp(dp), .an(an),
    .err(err), .count(count)
  );

  seg7_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_EN(1'b1)) dut_h (
    .clock(clk), .reset(rst_n), .op(op_h), .clr(1'b0), .wr_pos(pos_h),
    .wr_dig(dig_h), .wr_dp(1'b0), .seg(seg_h), .dp(dp_h), .an(an_h),
    .err(err_h), .count(count_h)
  );

  seg7_scan_ctrl #(.N_DIGITS(10), .REFRESH_DIV(DIV), .HEX_EN(1'b0)) dut_w (
    .clock(clk), .reset(rst_n), .op(op_w), .clr(1'b0), .wr_pos(pos_w),
    .wr_dig(dig_w), .wr_dp(1'b0), .seg(seg_w), .dp(dp_w), .an(an_w),
    .err(err_w), .count(count_w)
  );

  // Clock edges seen since reset release; edge 1 is the first live edge.
  int edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Display model: m[i] is position i (0 = rightmost).
  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       p;
  } dig_t;
  dig_t m[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected pattern built from the list of lit segments.
  function automatic logic [6:0] pat(input logic [3:0] d);
    string lit;
    logic [6:0] r;
    r = 7'h7F;
    case (d)
      4'd0:  lit = "abcdef";
      4'd1:  lit = "bc";
      4'd2:  lit = "abdeg";
      4'd3:  lit = "abcdg";
      4'd4:  lit = "bcfg";
      4'd5:  lit = "acdfg";
      4'd6:  lit = "acdefg";
      4'd7:  lit = "abc";
      4'd8:  lit = "abcdefg";
      4'd9:  lit = "abcdfg";
      4'd10: lit = "abcefg";
      4'd11: lit = "cdefg";
      4'd12: lit = "adef";
      4'd13: lit = "bcdeg";
      4'd14: lit = "adefg";
      default: lit = "aefg";
    endcase
    for (int i = 0; i < lit.len(); i++) r[lit[i] - 8'd97] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m.delete();
    for (int i = 0; i < N; i++) m.push_back('0);
  endtask

  function automatic int model_count();
    int c = 0;
    foreach (m[i]) if (m[i].v) c++;
    return c;
  endfunction

  task automatic model_apply(input logic c, input logic [1:0] o, input logic [2:0] p,
                             input logic [3:0] d, input logic dv, output logic e);
    dig_t nd;
    e  = 1'b0;
    nd = '{v: 1'b1, d: d, p: dv};
    if (c) begin
      model_reset();
    end else if (o == 2'd1) begin
      if (d > 9 || int'(p) >= N) e = 1'b1;
      else m[p] = nd;
    end else if (o == 2'd2) begin
      if (d > 9) e = 1'b1;
      else begin
        m.push_front(nd);
        void'(m.pop_back());
      end
    end else if (o == 2'd3) begin
      void'(m.pop_front());
      m.push_back('0);
    end
  endtask

  task automatic cmd(input logic c, input logic [1:0] o, input logic [2:0] p,
                     input logic [3:0] d, input logic dv);
    logic e;
    clr = c; op = o; wr_pos = p; wr_dig = d; wr_dp = dv;
    @(posedge clk); #1;
    clr = 1'b0; op = 2'd0;
    model_apply(c, o, p, d, dv, e);
    chk("cmd_err", {31'd0, err}, {31'd0, e});
    chk("cmd_count", {28'd0, count}, model_count());
  endtask

  // Compares the scanned bus against the model for n consecutive cycles.
  task automatic scan_check(input string tag, input int n);
    int idx;
    logic [7:0] one;
    dig_t ev;
    one = 8'h01;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idx = ((edge_n - 1) / DIV) % N;
      ev  = m[idx];
      chk({tag, "_an"},  {24'd0, an}, {24'd0, ~(one << idx)});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, ev.v ? pat(ev.d) : 7'h7F});
      chk({tag, "_dp"},  {31'd0, dp}, {31'd0, ~(ev.p & ev.v)});
      chk({tag, "_cnt"}, {28'd0, count}, model_count());
    end
  endtask

  initial begin
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cnt", {28'd0, count}, 32'd0);
    rst_n = 1'b1;
    scan_check("scan_blank", 40);

    // Positional write
    cmd(1'b0, 2'd1, 3'd3, 4'd7, 1'b1);
    scan_check("pos_write", 32);

    // Shift-in overflow
    cmd(1'b1, 2'd0, 3'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 9; i++) cmd(1'b0, 2'd2, 3'd0, 4'(i), 1'b0);
    scan_check("shift", 32);

    // Backspace
    repeat (3) cmd(1'b0, 2'd3, 3'd0, 4'd0, 1'b0);
    scan_check("bksp3", 32);
    repeat (8) cmd(1'b0, 2'd3, 3'd0, 4'd0, 1'b0);
    scan_check("bksp_empty", 16);

    // Rejects on the decimal build
    cmd(1'b0, 2'd1, 3'd5, 4'd4, 1'b1);
    cmd(1'b0, 2'd1, 3'd2, 4'd10, 1'b0);
    @(posedge clk); #1;
    chk("rej_err_drop", {31'd0, err}, 32'd0);
    cmd(1'b0, 2'd2, 3'd0, 4'd15, 1'b0);
    scan_check("rej_state", 32);

    // Hex build accepts code 10
    op_h = 2'd1; pos_h = 3'd2; dig_h = 4'd10;
    @(posedge clk); #1;
    op_h = 2'd0;
    chk("hex_err", {31'd0, err_h}, 32'd0);
    chk("hex_cnt", {28'd0, count_h}, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 32; k++) begin
      int idx;
      logic [7:0] one;
      one = 8'h01;
      @(negedge clk);
      idx = ((edge_n - 1) / DIV) % N;
      chk("hex_an", {24'd0, an_h}, {24'd0, ~(one << idx)});
      chk("hex_seg", {25'd0, seg_h}, (idx == 2) ? 32'h08 : 32'h7F);
    end

    // Ten-digit build: position 9 is in range, 10 and 15 are not
    op_w = 2'd1; pos_w = 4'd9; dig_w = 4'd3;
    @(posedge clk); #1;
    chk("w_pos9_err", {31'd0, err_w}, 32'd0);
    chk("w_pos9_cnt", {27'd0, count_w}, 32'd1);
    pos_w = 4'd10;
    @(posedge clk); #1;
    chk("w_pos10_err", {31'd0, err_w}, 32'd1);
    pos_w = 4'd15;
    @(posedge clk); #1;
    op_w = 2'd0;
    chk("w_pos15_err", {31'd0, err_w}, 32'd1);
    chk("w_pos15_cnt", {27'd0, count_w}, 32'd1);

    // clr beats a simultaneous write
    cmd(1'b0, 2'd2, 3'd0, 4'd8, 1'b1);
    cmd(1'b1, 2'd1, 3'd1, 4'd6, 1'b1);
    scan_check("clr_prio", 16);

    // Randomized command stream
    for (int i = 0; i < 120; i++) begin
      cmd(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    scan_check("rand", 32);

    // Asynchronous reset between edges mid-scan
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {24'd0, an}, 32'hFF);
    chk("arst_seg", {25'd0, seg}, 32'h7F);
    chk("arst_dp", {31'd0, dp}, 32'd1);
    chk("arst_cnt", {28'd0, count}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    scan_check("post_arst", 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
